conv_feature_serializer: RTL

Parametrised output stage for the convolution pipeline, placed between the `conv` engine and the board-level output pin. It captures the NUM_FILTERS-wide feature vector that `conv` presents on each valid cycle and buffers up to DEPTH vectors. Each channel is reduced from IN_WIDTH to OUT_WIDTH by round-and-saturate bit lopping, and the channels are streamed one per cycle on a valid/ready interface with channel index and end-of-frame marking. It supersedes the fixed six-filter, 16-bit post-processing path and adds backpressure, overflow detection and frame tracking.

---
 rtl/conv_feature_serializer_pkg.sv | 16 +
 rtl/conv_feature_serializer_feature_lop.sv | 46 ++++
 rtl/conv_feature_serializer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/conv_feature_serializer_pkg.sv
// Shared types for the convolution feature serializer.
// Optional build macro: CONV_SER_RELU_EN (clamps negative features to zero).
package conv_ser_pkg;

  localparam int CONV_FILTERS  = 6;
  localparam int CONV_IN_WIDTH = 16;

  typedef logic signed [CONV_IN_WIDTH-1:0] feature_t;
  typedef feature_t feature_vec_t [CONV_FILTERS];

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } ser_state_t;

endpackage

// File: rtl/conv_feature_serializer_feature_lop.sv
// Round-and-saturate bit lopping for one feature channel.
// Optional build macro: CONV_SER_RELU_EN (negative inputs forced to zero first).
module feature_lop #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 8,
  parameter int SHIFT     = 4
) (
  input  logic signed [IN_WIDTH-1:0]  din,
  output logic signed [OUT_WIDTH-1:0] dout
);

  localparam int W = IN_WIDTH + 1;
  localparam logic signed [W-1:0] RND =
    (SHIFT == 0) ? '0 : W'(1 << ((SHIFT == 0) ? 0 : SHIFT - 1));
  localparam logic signed [W-1:0] SAT_HI = W'((1 << (OUT_WIDTH - 1)) - 1);
`ifdef CONV_SER_RELU_EN
  localparam logic signed [W-1:0] SAT_LO = '0;
`else
  localparam logic signed [W-1:0] SAT_LO = ~SAT_HI;
`endif

  logic signed [W-1:0] ext;
  logic signed [W-1:0] rounded;
  logic signed [W-1:0] shifted;
  logic signed [W-1:0] sat;

  // Extend one bit so the rounding add cannot wrap, then shift and clamp
  always_comb begin
`ifdef CONV_SER_RELU_EN
    ext = din[IN_WIDTH-1] ? '0 : {1'b0, din};
`else
    ext = {din[IN_WIDTH-1], din};
`endif
    rounded = ext + RND;
    shifted = rounded >>> SHIFT;
    if (shifted > SAT_HI) begin
      sat = SAT_HI;
    end else if (shifted < SAT_LO) begin
      sat = SAT_LO;
    end else begin
      sat = shifted;
    end
    dout = OUT_WIDTH'(sat);
  end

endmodule

// File: rtl/conv_feature_serializer.sv
// Buffers conv feature vectors and streams lopped channels on valid/ready.
// Optional build macro: CONV_SER_RELU_EN (passed through to feature_lop).
module conv_feature_serializer
  import conv_ser_pkg::*;
#(
  parameter int NUM_FILTERS       = CONV_FILTERS,
  parameter int IN_WIDTH          = CONV_IN_WIDTH,
  parameter int OUT_WIDTH         = 8,
  parameter int SHIFT             = 4,
  parameter int DEPTH             = 4,
  parameter int VECTORS_PER_FRAME = 784
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic signed [IN_WIDTH-1:0]     in_features [NUM_FILTERS],
  output logic                           in_ready,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic signed [OUT_WIDTH-1:0]    m_data,
  output logic [$clog2(NUM_FILTERS)-1:0] m_chan,
  output logic                           m_last,
  output logic                           overflow,
  output logic [1:0]                     led,
  output logic                           led_r,
  output logic                           led_g,
  output logic                           led_b
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(NUM_FILTERS);
  localparam int FW = (VECTORS_PER_FRAME > 4) ? $clog2(VECTORS_PER_FRAME) : 2;
  localparam logic [CW-1:0] LAST_CHAN  = CW'(NUM_FILTERS - 1);
  localparam logic [FW-1:0] LAST_FRAME = FW'(VECTORS_PER_FRAME - 1);

  logic signed [IN_WIDTH-1:0] mem [DEPTH][NUM_FILTERS];
  logic [PW-1:0]  wr_ptr, rd_ptr, count;
  logic           full, empty;
  logic           hs, pop, wr_en, drop;
  ser_state_t     state;
  logic [FW-1:0]  frame_cnt, frame_nx;
  logic           load, bypass, last_nx;
  logic [AW-1:0]  load_addr;
  logic [CW-1:0]  load_chan;
  logic signed [IN_WIDTH-1:0]  src_feature;
  logic signed [OUT_WIDTH-1:0] lop_out;

  assign count    = wr_ptr - rd_ptr;
  assign empty    = (count == '0);
  assign full     = (count == PW'(DEPTH));
  assign hs       = m_valid && m_ready;
  assign pop      = hs && (m_chan == LAST_CHAN);
  assign wr_en    = in_valid && (!full || pop);
  assign drop     = in_valid && full && !pop;

  assign in_ready = !full;
  assign led      = frame_cnt[1:0];
  assign led_r    = overflow;
  assign led_g    = !overflow;
  assign led_b    = !empty;

  // Frame position after any head pop this cycle
  always_comb begin
    frame_nx = frame_cnt;
    if (pop) begin
      frame_nx = (frame_cnt == LAST_FRAME) ? '0 : frame_cnt + 1'b1;
    end
  end

  // Pick the channel to load into the output register next.
  // After the final channel pops with a single entry buffered, the next
  // vector can only be arriving this same cycle, so take it straight from
  // the input instead of the memory slot it is being written into.
  always_comb begin
    load      = 1'b0;
    bypass    = 1'b0;
    load_addr = rd_ptr[AW-1:0];
    load_chan = '0;
    case (state)
      ST_IDLE: load = !empty;
      ST_SEND: begin
        if (hs) begin
          if (!pop) begin
            load      = 1'b1;
            load_chan = m_chan + 1'b1;
          end else if (count != PW'(1) || wr_en) begin
            load      = 1'b1;
            load_addr = rd_ptr[AW-1:0] + 1'b1;
            bypass    = (count == PW'(1));
          end
        end
      end
      default: load = 1'b0;
    endcase
    src_feature = bypass ? in_features[load_chan] : mem[load_addr][load_chan];
    last_nx     = (load_chan == LAST_CHAN) && (frame_nx == LAST_FRAME);
  end

  feature_lop #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .SHIFT    (SHIFT)
  ) u_lop (
    .din (src_feature),
    .dout(lop_out)
  );

  // Vector storage, written whole on an accepted input
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned c = 0; c < NUM_FILTERS; c++) begin
        mem[wr_ptr[AW-1:0]][c] <= in_features[c];
      end
    end
  end

  // FIFO pointers, sticky overflow and frame counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (drop)  overflow <= 1'b1;
      frame_cnt <= frame_nx;
    end
  end

  // Output FSM with registered channel, data and frame marker
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_chan  <= '0;
      m_last  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            state   <= ST_SEND;
            m_valid <= 1'b1;
            m_data  <= lop_out;
            m_chan  <= load_chan;
            m_last  <= last_nx;
          end
        end
        ST_SEND: begin
          if (hs) begin
            if (load) begin
              m_data <= lop_out;
              m_chan <= load_chan;
              m_last <= last_nx;
            end else begin
              state   <= ST_IDLE;
              m_valid <= 1'b0;
              m_last  <= 1'b0;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          m_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
